// File: rtl/pwm_bank_pkg.sv
// pwm_bank_pkg: shared constants and types for the PWM bank.
//   - register map base addresses (7-bit write address space)
//   - last step of the period counter
//   - duty/counter width type and the byte-write request struct
package pwm_bank_pkg;

  typedef logic [7:0] duty_t;

  localparam logic [6:0] ADDR_OUT_EN = 7'h00;
  localparam logic [6:0] ADDR_PWM_EN = 7'h08;
  localparam logic [6:0] ADDR_PRESC  = 7'h10;
  localparam logic [6:0] ADDR_DUTY   = 7'h20;

  // cnt runs 0..PERIOD_MAX, i.e. 255 steps, so duty=255 is always high
  localparam duty_t PERIOD_MAX = 8'd254;

  typedef struct packed {
    logic       vld;
    logic [6:0] addr;
    logic [7:0] data;
  } wr_req_t;

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one PWM lane.
//   Holds a shadow duty (written by the register port) and an active duty
//   (copied from the shadow on the period wrap), compares the active duty
//   against the shared period counter and drives a registered output.
// Ports:
//   clk, rst_n     clock / async active-low reset
//   ena            design enable; low holds the output register
//   duty_we        shadow duty write strobe for this lane
//   wr_data        shadow duty write value
//   wrap           period wrap event (shadow -> active)
//   cnt            shared period counter
//   out_en, pwm_en output gate and modulation enable for this lane
//   pwm_out        registered lane output
//   pending        shadow differs from active
module pwm_channel
  import pwm_bank_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  ena,
  input  logic  duty_we,
  input  duty_t wr_data,
  input  logic  wrap,
  input  duty_t cnt,
  input  logic  out_en,
  input  logic  pwm_en,
  output logic  pwm_out,
  output logic  pending
);

  duty_t shadow;
  duty_t active;
  logic  raw;
  logic  mux;

  // A write landing on the wrap cycle goes to the shadow only; the active
  // copy takes the pre-write shadow value, so the new duty waits one period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (duty_we) shadow <= wr_data;
      if (wrap)    active <= shadow;
    end
  end

  assign raw = (cnt < active);
  // pwm_en low turns an enabled lane into a static high level
  assign mux = out_en & (pwm_en ? raw : 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   pwm_out <= 1'b0;
    else if (ena) pwm_out <= mux;
  end

  assign pending = (shadow != active);

endmodule

// File: rtl/pwm_bank_multi.sv
// pwm_bank_multi: NUM_CH-channel PWM bank with shared prescaler and period
// counter, byte-wide register write port and double-buffered duties.
// Ports:
//   clk, rst_n    clock / async active-low reset
//   ena           design enable; low freezes prescaler, counter and outputs
//   wr_valid      single-cycle register write strobe
//   wr_addr       register address (out_en 0x00+, pwm_en 0x08+, presc 0x10,
//                 duty 0x20+ch)
//   wr_data       register write data
//   pwm_out       registered channel outputs
//   period_start  one-clock pulse on the first clock of each period
//   upd_pending   any channel has a shadow duty awaiting the wrap
module pwm_bank_multi
  import pwm_bank_pkg::*;
#(
  parameter int NUM_CH    = 16,
  parameter int PRESC_RST = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              wr_valid,
  input  logic [6:0]        wr_addr,
  input  logic [7:0]        wr_data,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_start,
  output logic              upd_pending
);

  localparam int EN_BYTES = NUM_CH / 8;

  wr_req_t req;
  assign req = '{vld: wr_valid, addr: wr_addr, data: wr_data};

  // ---------------------------------------------------------------- enables
  logic [EN_BYTES-1:0][7:0] out_en_q;
  logic [EN_BYTES-1:0][7:0] pwm_en_q;
  logic [NUM_CH-1:0]        out_en_bits;
  logic [NUM_CH-1:0]        pwm_en_bits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_en_q <= '0;
      pwm_en_q <= '0;
    end else if (req.vld) begin
      for (int k = 0; k < EN_BYTES; k++) begin
        if (req.addr == ADDR_OUT_EN + 7'(k)) out_en_q[k] <= req.data;
        if (req.addr == ADDR_PWM_EN + 7'(k)) pwm_en_q[k] <= req.data;
      end
    end
  end

  assign out_en_bits = out_en_q;
  assign pwm_en_bits = pwm_en_q;

  // -------------------------------------------------------------- prescaler
  logic  presc_we;
  duty_t presc;
  duty_t pcnt;
  logic  tick;

  assign presc_we = req.vld && (req.addr == ADDR_PRESC);
  // tick uses the current presc/pcnt, so a presc write on a tick cycle
  // still lets that tick (and any wrap) happen
  assign tick     = ena && (pcnt == presc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= 8'(PRESC_RST);
      pcnt  <= '0;
    end else if (presc_we) begin
      presc <= req.data;
      pcnt  <= '0;
    end else if (ena) begin
      pcnt  <= tick ? '0 : pcnt + 8'd1;
    end
  end

  // --------------------------------------------------------- period counter
  duty_t cnt;
  logic  wrap;

  assign wrap = tick && (cnt == PERIOD_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      period_start <= 1'b0;
    end else begin
      if (tick) cnt <= (cnt == PERIOD_MAX) ? '0 : cnt + 8'd1;
      period_start <= wrap;
    end
  end

  // --------------------------------------------------------------- channels
  logic [NUM_CH-1:0] duty_we;
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] ch_out;

  always_comb begin
    duty_we = '0;
    for (int ch = 0; ch < NUM_CH; ch++)
      duty_we[ch] = req.vld && (req.addr == ADDR_DUTY + 7'(ch));
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_channel u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .duty_we (duty_we[g]),
      .wr_data (req.data),
      .wrap    (wrap),
      .cnt     (cnt),
      .out_en  (out_en_bits[g]),
      .pwm_en  (pwm_en_bits[g]),
      .pwm_out (ch_out[g]),
      .pending (pend[g])
    );
  end

  assign pwm_out     = ch_out;
  assign upd_pending = |pend;

endmodule

// File: tb/tb_pwm_bank_multi.sv
// tb_pwm_bank_multi: directed bench for pwm_bank_multi (NUM_CH=16, presc 12).
module tb_pwm_bank_multi;

  localparam int NUM_CH = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ena = 1'b1;
  logic              wr_valid = 1'b0;
  logic [6:0]        wr_addr = '0;
  logic [7:0]        wr_data = '0;
  logic [NUM_CH-1:0] pwm_out;
  logic              period_start;
  logic              upd_pending;

  pwm_bank_multi #(.NUM_CH(NUM_CH), .PRESC_RST(12)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .wr_valid     (wr_valid),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .upd_pending  (upd_pending)
  );

  always #5 clk = ~clk;

  // clocks since reset release
  int cyc = 0;
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int n_cmp = 0;
  int n_err = 0;
  int hi [NUM_CH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // called at a negedge; write registers on the following posedge
  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // advance to the next negedge that sees period_start
  task automatic wait_ps(output int c);
    bit found = 0;
    c = -1;
    for (int i = 0; i < 6000 && !found; i++) begin
      @(negedge clk);
      if (period_start) begin
        found = 1;
        c = cyc;
      end
    end
    if (!found) chk("ps_timeout", 0, 1);
  endtask

  // per-channel high count over n samples, starting with the current one
  task automatic meas(input int n);
    for (int ch = 0; ch < NUM_CH; ch++) hi[ch] = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      for (int ch = 0; ch < NUM_CH; ch++) hi[ch] += int'(pwm_out[ch]);
    end
  endtask

  int t0, t1, pre5;

  initial begin
    // ---- reset
    repeat (3) @(negedge clk);
    chk("rst_pwm_out", pwm_out, 0);
    chk("rst_period_start", period_start, 0);
    chk("rst_upd_pending", upd_pending, 0);
    rst_n = 1'b1;

    // ---- static enables, one clock of output latency
    wr(7'h00, 8'hFF);
    chk("en_latency", pwm_out, 0);
    @(negedge clk);
    chk("en_lo_byte", pwm_out[7:0], 8'hFF);
    chk("en_hi_byte", pwm_out[15:8], 8'h00);
    wr(7'h08, 8'h00);
    wait_ps(t0);
    chk("first_ps_cycle", t0, 3315);

    // ---- duty 0 / 128 / 255 on all-enabled lanes
    wr(7'h01, 8'hFF);
    wr(7'h08, 8'hFF);
    wr(7'h09, 8'hFF);
    wr(7'h23, 8'h80);
    wr(7'h20, 8'h00);
    wr(7'h21, 8'hFF);
    chk("pend_after_wr", upd_pending, 1);
    wait_ps(t0);
    chk("pend_after_wrap", upd_pending, 0);
    wait_ps(t0);
    meas(3315);
    chk("ch3_high_128", hi[3], 1664);
    chk("ch0_high_0", hi[0], 0);
    chk("ch1_high_255", hi[1], 3315);

    // ---- mid-period duty write deferred to wrap
    wait_ps(t0);
    repeat (1000) @(negedge clk);
    wr(7'h25, 8'h40);
    chk("pend_mid", upd_pending, 1);
    pre5 = 0;
    for (int i = 0; i < 5000 && !period_start; i++) begin
      pre5 += int'(pwm_out[5]);
      @(negedge clk);
    end
    chk("ps_seen_mid", period_start, 1);
    chk("ch5_before_wrap", pre5, 0);
    chk("pend_cleared", upd_pending, 0);
    meas(3315);
    chk("ch5_high_64", hi[5], 832);

    // ---- presc = 0
    wait_ps(t0);
    repeat (100) @(negedge clk);
    wr(7'h10, 8'h00);
    wait_ps(t0);
    wait_ps(t1);
    chk("ps_spacing_p0", t1 - t0, 255);
    meas(255);
    chk("ch3_p0", hi[3], 128);
    chk("ch5_p0", hi[5], 64);

    // ---- write on the exact wrap cycle
    wait_ps(t0);
    repeat (254) @(negedge clk);
    wr(7'h22, 8'h80);
    chk("wrap_cycle_ps", period_start, 1);
    chk("wrap_cycle_pend", upd_pending, 1);
    meas(255);
    chk("ch2_not_applied", hi[2], 0);
    wait_ps(t0);
    chk("ch2_pend_clear", upd_pending, 0);
    meas(255);
    chk("ch2_applied", hi[2], 128);

    // ---- async reset mid-period
    repeat (50) @(negedge clk);
    chk("pre_rst_ch1", pwm_out[1], 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out", pwm_out, 0);
    chk("async_rst_pend", upd_pending, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wr(7'h30, 8'h55);
    chk("unmapped_pend", upd_pending, 0);
    wr(7'h00, 8'hFF);
    wr(7'h01, 8'hFF);
    wr(7'h08, 8'hFF);
    wr(7'h09, 8'hFF);
    @(negedge clk);
    chk("duties_zero", pwm_out, 0);
    wait_ps(t0);
    chk("presc_reloaded", t0, 3315);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
